// File: rtl/arm_cond_pkg.sv
// Shared types and constants for the ARM conditional-execution unit.
// Condition encodings, NZCV bit positions and the default reset flags.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    HS = 4'h2,
    LO = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } condition_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] RESET_FLAGS = 4'b0000;

endpackage

// File: rtl/arm_cond_exec_unit_if.sv
// Bundle of decode-side controls and execute-side results for the
// conditional-execution unit. The decode stage is the master; the unit is
// the slave.
interface arm_cond_exec_unit_if;

  logic       i_Valid_Execute;
  logic       i_Stall;
  logic [3:0] i_Cond;
  logic [1:0] i_FlagWrite;
  logic [3:0] i_ALU_Flags;
  logic       i_IT_Start;
  logic [3:0] i_IT_FirstCond;
  logic [3:0] i_IT_Mask;
  logic       o_CondEx_Execute;
  logic [1:0] o_FlagWrite_Eff;
  logic [3:0] o_Flags;
  logic       o_IT_Active;
  logic       o_IT_Fault;

  modport master (
    output i_Valid_Execute, i_Stall, i_Cond, i_FlagWrite, i_ALU_Flags,
           i_IT_Start, i_IT_FirstCond, i_IT_Mask,
    input  o_CondEx_Execute, o_FlagWrite_Eff, o_Flags, o_IT_Active, o_IT_Fault
  );

  modport slave (
    input  i_Valid_Execute, i_Stall, i_Cond, i_FlagWrite, i_ALU_Flags,
           i_IT_Start, i_IT_FirstCond, i_IT_Mask,
    output o_CondEx_Execute, o_FlagWrite_Eff, o_Flags, o_IT_Active, o_IT_Fault
  );

endinterface

// File: rtl/arm_cond_eval.sv
// Pure combinational evaluation of an ARM condition code against NZCV.
module arm_cond_eval
  import arm_cond_pkg::*;
(
  input  condition_t cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition into a single pass/fail bit; NV never passes.
  always_comb begin
    pass = 1'b0;
    case (cond)
      EQ: pass = z;
      NE: pass = ~z;
      HS: pass = c;
      LO: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_cond_exec_unit.sv
// Execute-stage conditional-execution unit: owns the NZCV register, gates
// execute and flag-write permission, and optionally sequences IT blocks.
// Optional feature macro: COND_EXEC_IT_EN (IT-block sequencer).
module arm_cond_exec_unit #(
  parameter logic [3:0] RESET_FLAGS = arm_cond_pkg::RESET_FLAGS
) (
  input logic              i_CLK,
  input logic              i_RST,
  arm_cond_exec_unit_if.slave bus
);

  import arm_cond_pkg::*;

  logic       adv;
  logic [3:0] ec;
  logic       cond_pass;
  logic       cond_ex;
  logic [3:0] flags;
  logic       it_active;
  logic       it_fault;

  assign adv = bus.i_Valid_Execute & ~bus.i_Stall;

`ifdef COND_EXEC_IT_EN
  logic [7:0] it_state;
  logic       it_legal;

  assign it_active = (it_state[3:0] != 4'b0000);
  assign ec        = it_active ? it_state[7:4] : bus.i_Cond;
  assign it_legal  = ~it_active & (bus.i_IT_Mask != 4'b0000) &
                     (bus.i_IT_FirstCond != 4'hF);

  // IT sequencer: load on a legal IT, otherwise consume one slot per
  // advancing instruction until the mask marker shifts out.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      it_state <= 8'h00;
    end else if (adv) begin
      if (bus.i_IT_Start && it_legal) begin
        it_state <= {bus.i_IT_FirstCond, bus.i_IT_Mask};
      end else if (it_active) begin
        if (it_state[2:0] == 3'b000) begin
          it_state <= 8'h00;
        end else begin
          it_state[4:0] <= {it_state[3:0], 1'b0};
        end
      end
    end
  end

  // Fault pulse for an IT that could not be accepted; frozen while stalled.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      it_fault <= 1'b0;
    end else if (!bus.i_Stall) begin
      it_fault <= adv & bus.i_IT_Start & ~it_legal;
    end
  end
`else
  logic unused_it;

  assign unused_it = ^{bus.i_IT_Start, bus.i_IT_FirstCond, bus.i_IT_Mask};
  assign it_active = 1'b0;
  assign it_fault  = 1'b0;
  assign ec        = bus.i_Cond;
`endif

  arm_cond_eval u_eval (
    .cond  (condition_t'(ec)),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign cond_ex = bus.i_Valid_Execute & cond_pass;

  // Architectural NZCV: each half is written only when the instruction
  // actually executes and asks for that half.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      flags <= RESET_FLAGS;
    end else if (adv && cond_ex) begin
      if (bus.i_FlagWrite[1]) begin
        flags[FLAG_N] <= bus.i_ALU_Flags[FLAG_N];
        flags[FLAG_Z] <= bus.i_ALU_Flags[FLAG_Z];
      end
      if (bus.i_FlagWrite[0]) begin
        flags[FLAG_C] <= bus.i_ALU_Flags[FLAG_C];
        flags[FLAG_V] <= bus.i_ALU_Flags[FLAG_V];
      end
    end
  end

  assign bus.o_CondEx_Execute = cond_ex;
  assign bus.o_FlagWrite_Eff  = bus.i_FlagWrite & {2{cond_ex}};
  assign bus.o_Flags          = flags;
  assign bus.o_IT_Active      = it_active;
  assign bus.o_IT_Fault       = it_fault;

endmodule

// File: tb/tb_arm_cond_exec_unit.sv
// Directed self-checking bench for arm_cond_exec_unit.
// Expectations for IT behaviour follow COND_EXEC_IT_EN as seen by this file.
module tb_arm_cond_exec_unit;

`ifdef COND_EXEC_IT_EN
  localparam bit IT_EN = 1'b1;
`else
  localparam bit IT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  arm_cond_exec_unit_if bus ();

  arm_cond_exec_unit #(.RESET_FLAGS(4'b0100)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one Execute-slot vector and let combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic stall,
                               input logic [3:0] cond, input logic [1:0] fw,
                               input logic [3:0] alu, input logic itStart,
                               input logic [3:0] firstCond,
                               input logic [3:0] mask);
    bus.i_Valid_Execute = valid;
    bus.i_Stall         = stall;
    bus.i_Cond          = cond;
    bus.i_FlagWrite     = fw;
    bus.i_ALU_Flags     = alu;
    bus.i_IT_Start      = itStart;
    bus.i_IT_FirstCond  = firstCond;
    bus.i_IT_Mask       = mask;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain executing instruction that writes both flag halves.
  task automatic setFlags(input logic [3:0] value);
    applyStimulus(1, 0, 4'hE, 2'b11, value, 0, 4'h0, 4'h0);
    tick();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("reset_flags", {4'h0, bus.o_Flags}, 8'h04);
    checkOutput("reset_it_active", {7'h0, bus.o_IT_Active}, 8'h00);
    checkOutput("reset_it_fault", {7'h0, bus.o_IT_Fault}, 8'h00);

    // Basic conditions against Z=1
    applyStimulus(1, 0, 4'h0, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("eq_z1", {7'h0, bus.o_CondEx_Execute}, 8'h01);
    applyStimulus(1, 0, 4'h1, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("ne_z1", {7'h0, bus.o_CondEx_Execute}, 8'h00);
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("al", {7'h0, bus.o_CondEx_Execute}, 8'h01);
    applyStimulus(1, 0, 4'hF, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("nv", {7'h0, bus.o_CondEx_Execute}, 8'h00);
    tick();

    // CMP-style write from 0000 to 1001, then signed/unsigned checks
    setFlags(4'h0);
    checkOutput("flags_cleared", {4'h0, bus.o_Flags}, 8'h00);
    applyStimulus(1, 0, 4'hE, 2'b11, 4'h9, 0, 4'h0, 4'h0);
    checkOutput("cmp_fweff", {6'h0, bus.o_FlagWrite_Eff}, 8'h03);
    tick();
    checkOutput("cmp_flags", {4'h0, bus.o_Flags}, 8'h09);
    begin
      logic [3:0] condList [8] = '{4'hB, 4'hA, 4'h4, 4'h6, 4'h2, 4'h8, 4'h9, 4'hC};
      logic       expList  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1, 0, condList[i], 2'b00, 4'h0, 0, 4'h0, 4'h0);
        checkOutput($sformatf("cond_%0h_1001", condList[i]),
                    {7'h0, bus.o_CondEx_Execute}, {7'h0, expList[i]});
      end
    end
    applyStimulus(1, 0, 4'hD, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("le_1001", {7'h0, bus.o_CondEx_Execute}, 8'h00);
    tick();

    // Failing NE must block its flag write
    setFlags(4'h6);
    applyStimulus(1, 0, 4'h1, 2'b11, 4'h9, 0, 4'h0, 4'h0);
    checkOutput("ne_fail_condex", {7'h0, bus.o_CondEx_Execute}, 8'h00);
    checkOutput("ne_fail_fweff", {6'h0, bus.o_FlagWrite_Eff}, 8'h00);
    tick();
    checkOutput("ne_fail_flags", {4'h0, bus.o_Flags}, 8'h06);

    // Partial writes keep the other half
    applyStimulus(1, 0, 4'hE, 2'b10, 4'h9, 0, 4'h0, 4'h0);
    tick();
    checkOutput("write_nz_only", {4'h0, bus.o_Flags}, 8'h0A);
    applyStimulus(1, 0, 4'hE, 2'b01, 4'h5, 0, 4'h0, 4'h0);
    tick();
    checkOutput("write_cv_only", {4'h0, bus.o_Flags}, 8'h09);

    // Bubble and stall must not touch flags
    applyStimulus(0, 0, 4'hE, 2'b11, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("bubble_condex", {7'h0, bus.o_CondEx_Execute}, 8'h00);
    checkOutput("bubble_fweff", {6'h0, bus.o_FlagWrite_Eff}, 8'h00);
    tick();
    checkOutput("bubble_flags", {4'h0, bus.o_Flags}, 8'h09);
    applyStimulus(1, 1, 4'hE, 2'b11, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("stall_condex", {7'h0, bus.o_CondEx_Execute}, 8'h01);
    checkOutput("stall_fweff", {6'h0, bus.o_FlagWrite_Eff}, 8'h03);
    tick();
    checkOutput("stall_flags", {4'h0, bus.o_Flags}, 8'h09);

    // IT EQ, mask 0110: slots EQ, EQ, NE with Z=1; own cond is NE
    setFlags(4'h4);
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 1, 4'h0, 4'h6);
    checkOutput("it_instr_condex", {7'h0, bus.o_CondEx_Execute}, 8'h01);
    tick();
    checkOutput("it_active_start", {7'h0, bus.o_IT_Active}, {7'h0, IT_EN});
    begin
      logic expEx  [3] = '{IT_EN, IT_EN, 1'b0};
      logic expAct [3] = '{IT_EN, IT_EN, 1'b0};
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1, 0, 4'h1, 2'b00, 4'h0, 0, 4'h0, 4'h0);
        checkOutput($sformatf("it_slot%0d_condex", i),
                    {7'h0, bus.o_CondEx_Execute}, {7'h0, expEx[i]});
        tick();
        checkOutput($sformatf("it_slot%0d_active", i),
                    {7'h0, bus.o_IT_Active}, {7'h0, expAct[i]});
      end
    end

    // One-slot IT held by stalls and a bubble
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 1, 4'h0, 4'h8);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 4'h1, 2'b00, 4'h0, 0, 4'h0, 4'h0);
      checkOutput($sformatf("it_stall%0d_condex", i),
                  {7'h0, bus.o_CondEx_Execute}, {7'h0, IT_EN});
      tick();
      checkOutput($sformatf("it_stall%0d_active", i),
                  {7'h0, bus.o_IT_Active}, {7'h0, IT_EN});
    end
    applyStimulus(0, 0, 4'h1, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    tick();
    checkOutput("it_bubble_active", {7'h0, bus.o_IT_Active}, {7'h0, IT_EN});
    applyStimulus(1, 0, 4'h1, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    checkOutput("it_last_condex", {7'h0, bus.o_CondEx_Execute}, {7'h0, IT_EN});
    tick();
    checkOutput("it_last_active", {7'h0, bus.o_IT_Active}, 8'h00);

    // Illegal IT starts
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 1, 4'h0, 4'h0);
    tick();
    checkOutput("fault_mask0", {7'h0, bus.o_IT_Fault}, {7'h0, IT_EN});
    checkOutput("fault_mask0_active", {7'h0, bus.o_IT_Active}, 8'h00);
    applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    tick();
    checkOutput("fault_clears", {7'h0, bus.o_IT_Fault}, 8'h00);
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 1, 4'hF, 4'h8);
    tick();
    checkOutput("fault_nv", {7'h0, bus.o_IT_Fault}, {7'h0, IT_EN});
    checkOutput("fault_nv_active", {7'h0, bus.o_IT_Active}, 8'h00);

    // IT while active (two-slot block): fault, slot still consumed
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 1, 4'h0, 4'h4);
    tick();
    applyStimulus(1, 0, 4'hE, 2'b00, 4'h0, 1, 4'h1, 4'h8);
    tick();
    checkOutput("fault_nested", {7'h0, bus.o_IT_Fault}, {7'h0, IT_EN});
    checkOutput("nested_active", {7'h0, bus.o_IT_Active}, {7'h0, IT_EN});

    // Reset in the middle of the block
    applyStimulus(0, 0, 4'hE, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_active", {7'h0, bus.o_IT_Active}, 8'h00);
    checkOutput("rst_mid_flags", {4'h0, bus.o_Flags}, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
